calc_cmd_issuer: RTL and testbench

Sequential initiator that sits in front of the combinational 4-bit calculator. It accepts operation commands over a valid/ready stream and screens out illegal ones. Legal commands are driven onto the calculator's operand/opcode ports as registered signals, and each 8-bit result is captured into a response FIFO. Results are returned downstream in command order over a second valid/ready stream, each with an error flag.

---
 rtl/calc_pkg.sv | 31 +++
 rtl/calc_rsp_fifo.sv | 54 +++++
 rtl/calc_cmd_issuer.sv | 115 +++++++++++
 tb/tb_calc_cmd_issuer.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared opcodes, FSM state type, response entry layout and command screening.
package calc_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;
    localparam logic [2:0] OP_MOD = 3'b100;
    localparam logic [2:0] OP_NEG = 3'b101;

    typedef enum logic {
        ST_IDLE,
        ST_DRIVE
    } state_t;

    typedef struct packed {
        logic [2:0] oper;
        logic       err;
        logic [7:0] data;
    } rsp_entry_t;

    // Undefined opcodes, and divide/modulo by zero, never reach the calculator.
    function automatic logic is_illegal(input logic [2:0] oper, input logic [3:0] b);
        logic bad_op;
        logic zero_div;
        bad_op   = (oper == 3'b110) || (oper == 3'b111);
        zero_div = ((oper == OP_DIV) || (oper == OP_MOD)) && (b == 4'h0);
        return bad_op || zero_div;
    endfunction

endpackage

// File: rtl/calc_rsp_fifo.sv
// Synchronous response FIFO; head is read combinationally from the storage array.
module calc_rsp_fifo
    import calc_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  rsp_entry_t wr_entry,
    output rsp_entry_t head,
    output logic       full,
    output logic       empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    // Extra MSB on each pointer distinguishes full from empty when addresses match.
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    rsp_entry_t  mem [DEPTH];

    logic do_push;
    logic do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointer advance on accepted push/pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW + 1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW + 1)'(1);
        end
    end

    // Storage write; cleared on reset so the idle head reads as zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= wr_entry;
        end
    end

    assign head  = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/calc_cmd_issuer.sv
// Screens calculator commands, drives legal ones to the calculator for one cycle,
// and queues every result (or error marker) for in-order return downstream.
module calc_cmd_issuer
    import calc_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_oper,
    input  logic [3:0] cmd_a,
    input  logic [3:0] cmd_b,
    output logic [3:0] calc_a,
    output logic [3:0] calc_b,
    output logic [2:0] calc_oper,
    input  logic [7:0] calc_out,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic [2:0] rsp_oper,
    output logic       rsp_err,
    output logic [7:0] err_count
);

    state_t     state;
    state_t     state_nxt;
    logic       accept;
    logic       illegal;
    logic       push;
    rsp_entry_t push_entry;
    rsp_entry_t head;
    logic       full;
    logic       empty;

    assign illegal = is_illegal(cmd_oper, cmd_b);
    assign accept  = cmd_valid && cmd_ready;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next state, handshake and FIFO push selection.
    always_comb begin
        state_nxt  = state;
        cmd_ready  = 1'b0;
        push       = 1'b0;
        push_entry = '0;
        case (state)
            ST_IDLE: begin
                cmd_ready = !full;
                if (cmd_valid && !full) begin
                    if (illegal) begin
                        push            = 1'b1;
                        push_entry.oper = cmd_oper;
                        push_entry.err  = 1'b1;
                    end else begin
                        state_nxt = ST_DRIVE;
                    end
                end
            end
            ST_DRIVE: begin
                push            = 1'b1;
                push_entry.oper = calc_oper;
                push_entry.data = calc_out;
                state_nxt       = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Calculator operands load only for legal accepted commands and hold otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            calc_a    <= '0;
            calc_b    <= '0;
            calc_oper <= OP_ADD;
        end else if (accept && !illegal) begin
            calc_a    <= cmd_a;
            calc_b    <= cmd_b;
            calc_oper <= cmd_oper;
        end
    end

    // Saturating count of accepted illegal commands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count <= '0;
        end else if (accept && illegal && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
        end
    end

    calc_rsp_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .pop      (rsp_valid && rsp_ready),
        .wr_entry (push_entry),
        .head     (head),
        .full     (full),
        .empty    (empty)
    );

    assign rsp_valid = !empty;
    assign rsp_data  = head.data;
    assign rsp_oper  = head.oper;
    assign rsp_err   = head.err;

endmodule

// File: tb/tb_calc_cmd_issuer.sv
// Randomized and directed bench for calc_cmd_issuer against a queue-based reference model.
module tb_calc_cmd_issuer;

    localparam int DEPTH = 4;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_oper;
    logic [3:0] cmd_a;
    logic [3:0] cmd_b;
    logic [3:0] calc_a;
    logic [3:0] calc_b;
    logic [2:0] calc_oper;
    logic [7:0] calc_out;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic [2:0] rsp_oper;
    logic       rsp_err;
    logic [7:0] err_count;

    int n_vec  = 0;
    int n_fail = 0;

    calc_cmd_issuer #(
        .DEPTH(DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_oper  (cmd_oper),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .calc_a    (calc_a),
        .calc_b    (calc_b),
        .calc_oper (calc_oper),
        .calc_out  (calc_out),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_oper  (rsp_oper),
        .rsp_err   (rsp_err),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The combinational 4-bit calculator, results truncated to 8 bits.
    function automatic int calc_fn(int op, int a, int b);
        case (op)
            0: return (a + b) & 255;
            1: return (a - b) & 255;
            2: return (a * b) & 255;
            3: return (b == 0) ? 0 : a / b;
            4: return (b == 0) ? 0 : a % b;
            5: return (~a) & 255;
            default: return 0;
        endcase
    endfunction

    always_comb calc_out = 8'(calc_fn(int'(calc_oper), int'(calc_a), int'(calc_b)));

    // ---------------- reference model ----------------
    typedef struct {
        int oper;
        bit err;
        int data;
    } rsp_t;

    rsp_t q[$];
    bit   m_busy;
    int   m_a, m_b, m_op, m_errs;

    function automatic bit bad_cmd(int op, int b);
        return (op > 5) || ((op == 3 || op == 4) && b == 0);
    endfunction

    task automatic model_reset();
        q.delete();
        m_busy = 0;
        m_a = 0; m_b = 0; m_op = 0; m_errs = 0;
    endtask

    function automatic bit model_ready();
        return !m_busy && (q.size() < DEPTH);
    endfunction

    task automatic model_step();
        bit was_ready;
        rsp_t e;
        was_ready = model_ready();
        if (q.size() > 0 && rsp_ready) void'(q.pop_front());
        if (m_busy) begin
            e.oper = m_op; e.err = 0; e.data = calc_fn(m_op, m_a, m_b);
            q.push_back(e);
            m_busy = 0;
        end else if (cmd_valid && was_ready) begin
            if (bad_cmd(int'(cmd_oper), int'(cmd_b))) begin
                e.oper = int'(cmd_oper); e.err = 1; e.data = 0;
                q.push_back(e);
                if (m_errs < 255) m_errs++;
            end else begin
                m_a = int'(cmd_a); m_b = int'(cmd_b); m_op = int'(cmd_oper);
                m_busy = 1;
            end
        end
    endtask

    task automatic chk(string nm, int act, int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model advances just after each edge, using the inputs held across that edge.
    always @(posedge clk) begin
        #1;
        if (rst) model_reset();
        else     model_step();
    end

    // Compare DUT outputs against the model on every falling edge outside reset.
    always @(negedge clk) begin
        if (!rst) begin
            chk("cmd_ready", int'(cmd_ready), int'(model_ready()));
            chk("rsp_valid", int'(rsp_valid), int'(q.size() > 0));
            if (q.size() > 0) begin
                chk("rsp_data", int'(rsp_data), q[0].data);
                chk("rsp_oper", int'(rsp_oper), q[0].oper);
                chk("rsp_err",  int'(rsp_err),  int'(q[0].err));
            end
            chk("calc_a",    int'(calc_a),    m_a);
            chk("calc_b",    int'(calc_b),    m_b);
            chk("calc_oper", int'(calc_oper), m_op);
            chk("err_count", int'(err_count), m_errs);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_cmd(int op, int a, int b);
        cmd_valid = 1'b1;
        cmd_oper  = 3'(op);
        cmd_a     = 4'(a);
        cmd_b     = 4'(b);
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_oper = '0; cmd_a = '0; cmd_b = '0; rsp_ready = 1'b0;
        model_reset();
        repeat (3) step();
        rst = 1'b0;

        // Reset values.
        @(negedge clk);
        chk("rst_cmd_ready", int'(cmd_ready), 1);
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        chk("rst_calc_a", int'(calc_a), 0);
        chk("rst_err_count", int'(err_count), 0);

        // Add 3+5.
        set_cmd(0, 3, 5);
        step();
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("add_calc_a", int'(calc_a), 3);
        chk("add_calc_b", int'(calc_b), 5);
        chk("add_early_valid", int'(rsp_valid), 0);
        step();
        @(negedge clk);
        chk("add_valid", int'(rsp_valid), 1);
        chk("add_data", int'(rsp_data), 8'h08);
        chk("add_err", int'(rsp_err), 0);
        rsp_ready = 1'b1; step(); rsp_ready = 1'b0;

        // Div 9/0 is illegal.
        set_cmd(3, 9, 0);
        step();
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("div0_valid", int'(rsp_valid), 1);
        chk("div0_data", int'(rsp_data), 0);
        chk("div0_err", int'(rsp_err), 1);
        chk("div0_oper", int'(rsp_oper), 3);
        chk("div0_errcnt", int'(err_count), 1);
        chk("div0_calc_a", int'(calc_a), 3);
        rsp_ready = 1'b1; step(); rsp_ready = 1'b0;

        // Fill the FIFO: mul 2*3, mul 15*15, sub 1-2, mod 7%3.
        set_cmd(2, 2, 3);   step(); cmd_valid = 1'b0; step();
        set_cmd(2, 15, 15); step(); cmd_valid = 1'b0; step();
        set_cmd(1, 1, 2);   step(); cmd_valid = 1'b0; step();
        set_cmd(4, 7, 3);   step(); cmd_valid = 1'b0; step();
        @(negedge clk);
        chk("full_ready", int'(cmd_ready), 0);
        chk("full_head", int'(rsp_data), 8'h06);

        // Pop and offer in the same cycle: only the pop happens.
        set_cmd(0, 1, 1);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("pop_ready", int'(cmd_ready), 1);
        chk("pop_head", int'(rsp_data), 8'hE1);
        step();
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        step();
        @(negedge clk);
        chk("drain_ff", int'(rsp_data), 8'hFF);
        step();
        @(negedge clk);
        chk("drain_01", int'(rsp_data), 8'h01);
        repeat (4) step();

        // 300 back-to-back illegal opcodes.
        set_cmd(7, 1, 1);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            chk("ill_ready", int'(cmd_ready), 1);
            step();
        end
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("ill_sat", int'(err_count), 8'hFF);
        repeat (3) step();

        // Reset during DRIVE of add 4+4.
        rsp_ready = 1'b0;
        set_cmd(0, 4, 4);
        step();
        cmd_valid = 1'b0;
        rst = 1'b1;
        model_reset();
        #1;
        chk("rstd_calc_a", int'(calc_a), 0);
        chk("rstd_errcnt", int'(err_count), 0);
        chk("rstd_valid", int'(rsp_valid), 0);
        #1;
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("rstd_no_rsp", int'(rsp_valid), 0);
        end
        step();
        set_cmd(0, 2, 2);
        step();
        cmd_valid = 1'b0;
        step();
        @(negedge clk);
        chk("post_rst_data", int'(rsp_data), 8'h04);
        rsp_ready = 1'b1;
        step();

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_oper  = 3'($urandom_range(0, 7));
            cmd_a     = 4'($urandom_range(0, 15));
            cmd_b     = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            rsp_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        repeat (DEPTH + 4) step();
        @(negedge clk);
        chk("final_empty", int'(rsp_valid), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
